// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes,
// funct codes, ALU operation codes, mux selects and the control word.
package mips_ctrl_pkg;

    typedef logic [4:0] state_t;

    localparam state_t S_RST      = 5'd0;
    localparam state_t S_F0       = 5'd1;
    localparam state_t S_F1       = 5'd2;
    localparam state_t S_F2       = 5'd3;
    localparam state_t S_DEC      = 5'd4;
    localparam state_t S_R_EX     = 5'd5;
    localparam state_t S_R_WB     = 5'd6;
    localparam state_t S_ADDI_EX  = 5'd7;
    localparam state_t S_ADDI_WB  = 5'd8;
    localparam state_t S_MEM_ADDR = 5'd9;
    localparam state_t S_LW_RD    = 5'd10;
    localparam state_t S_LW_WAIT  = 5'd11;
    localparam state_t S_LW_WB    = 5'd12;
    localparam state_t S_SW_WR    = 5'd13;
    localparam state_t S_BR       = 5'd14;
    localparam state_t S_JMP      = 5'd15;
    localparam state_t S_EXC_EPC  = 5'd16;
    localparam state_t S_EXC_JMP  = 5'd17;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC    = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       ab_write;
        logic       epc_write;
    } ctrl_t;

    function automatic logic funct_valid(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) ||
               (funct == FN_AND) || (funct == FN_XOR);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational output decode: one control word per state. The branch
// PCWrite is the only output that also depends on a live input (Zero).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [4:0] state,
    input  logic [5:0] funct,
    input  logic       op_lsb,
    input  logic       zero,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_F0, S_F1, S_F2: begin
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                if (state == S_F2) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCS_ALU;
                end
            end
            S_DEC: begin
                ctrl.alu_src_b     = SRCB_IMM2;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                ctrl.ab_write      = 1'b1;
            end
            S_R_EX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_out_write = 1'b1;
                case (funct)
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_EX, S_MEM_ADDR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_IMM;
                ctrl.alu_op        = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            S_LW_RD, S_LW_WAIT: ctrl.i_or_d = 1'b1;
            S_LW_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_SW_WR: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            // opcode bit 0 separates bne (0x05) from beq (0x04)
            S_BR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCS_ALUOUT;
                ctrl.pc_write  = zero ^ op_lsb;
            end
            S_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            S_EXC_EPC: begin
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_SUB;
                ctrl.epc_write = 1'b1;
            end
            S_EXC_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_EXC;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// exception cause register; outputs come from mips_ctrl_decode.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic [1:0] PCSource,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ALUOutWrite,
    output logic       ABWrite,
    output logic       EPCWrite,
    output logic       ExcCause,
    output logic [4:0] State
);

    state_t cur_state;
    state_t nxt_state;
    logic   cause_nxt;
    logic   exc_cause;
    logic   arith_op;
    ctrl_t  ctrl;

    assign arith_op = (FUNCT == FN_ADD) || (FUNCT == FN_SUB);

    always_comb begin
        nxt_state = S_RST;
        cause_nxt = 1'b0;
        case (cur_state)
            S_RST: nxt_state = S_F0;
            S_F0:  nxt_state = S_F1;
            S_F1:  nxt_state = S_F2;
            S_F2:  nxt_state = S_DEC;
            S_DEC: begin
                case (OPCODE)
                    OP_R:         nxt_state = funct_valid(FUNCT) ? S_R_EX : S_EXC_EPC;
                    OP_ADDI:      nxt_state = S_ADDI_EX;
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt_state = S_BR;
                    OP_J:         nxt_state = S_JMP;
                    default:      nxt_state = S_EXC_EPC;
                endcase
            end
            S_R_EX: begin
                cause_nxt = 1'b1;
                nxt_state = (Overflow && arith_op) ? S_EXC_EPC : S_R_WB;
            end
            S_ADDI_EX: begin
                cause_nxt = 1'b1;
                nxt_state = Overflow ? S_EXC_EPC : S_ADDI_WB;
            end
            S_MEM_ADDR: nxt_state = (OPCODE == OP_SW) ? S_SW_WR : S_LW_RD;
            S_LW_RD:    nxt_state = S_LW_WAIT;
            S_LW_WAIT:  nxt_state = S_LW_WB;
            S_EXC_EPC:  nxt_state = S_EXC_JMP;
            S_R_WB, S_ADDI_WB, S_LW_WB, S_SW_WR, S_BR, S_JMP, S_EXC_JMP:
                nxt_state = S_F0;
            default:    nxt_state = S_RST;
        endcase
    end

    // EXC_EPC never loops on itself, so entering it is the only latch point
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= S_RST;
            exc_cause <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state == S_EXC_EPC)
                exc_cause <= cause_nxt;
        end
    end

    mips_ctrl_decode u_decode (
        .state  (cur_state),
        .funct  (FUNCT),
        .op_lsb (OPCODE[0]),
        .zero   (Zero),
        .ctrl   (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCSource    = ctrl.pc_source;
    assign IorD        = ctrl.i_or_d;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign RegWrite    = ctrl.reg_write;
    assign RegDst      = ctrl.reg_dst;
    assign MemToReg    = ctrl.mem_to_reg;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign ALUOutWrite = ctrl.alu_out_write;
    assign ABWrite     = ctrl.ab_write;
    assign EPCWrite    = ctrl.epc_write;
    assign ExcCause    = exc_cause;
    assign State       = cur_state;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM for the multicycle MIPS datapath. It sequences the shared ALU, including its ALUSrcA/ALUSrcB operand muxes, the memory, the IR, the register file, PC and EPC through fetch, decode, execute, memory and writeback steps. It supports R-type add/sub/and/xor, addi, lw, sw, beq, bne and j. It detects invalid opcodes and arithmetic overflow and redirects to an exception vector.

Parameters:
None. All encodings are fixed constants in the shared package.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
OPCODE  input  6  IR[31:26]
FUNCT  input  6  IR[5:0]
Zero  input  1  ALU zero flag, combinational
Overflow  input  1  ALU overflow flag, combinational
PCWrite  output  1  PC load enable
PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector
IorD  output  1  memory address: 0 PC, 1 ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  IR load enable
RegWrite  output  1  register file write enable
RegDst  output  1  destination: 0 rt, 1 rd
MemToReg  output  1  writeback data: 0 ALUOut, 1 MDR
ALUSrcA  output  1  ALU operand A: 0 PC, 1 A
ALUSrcB  output  2  ALU operand B: 00 B, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2
ALUOp  output  3  ALU function: 001 add, 010 sub, 011 and, 110 xor
ALUOutWrite  output  1  ALUOut load enable
ABWrite  output  1  A/B register load enable
EPCWrite  output  1  EPC load enable
ExcCause  output  1  registered cause: 0 invalid opcode/funct, 1 overflow
State  output  5  current state, for debug

Behaviour:
- One clock. Reset is synchronous and active-high; ports are named clk and reset.
- reset sampled high: state <= RST, ExcCause <= 0. Every output decoded from RST is 0. reset overrides any in-flight sequence; no write strobe may assert in the cycle after the reset edge.
- Memory read latency is 1 cycle, hence the wait states.
- All outputs not listed for a state are 0. ALUSrcA/ALUSrcB/ALUOp hold the listed values only in the listed states.
- RST -> F0.
- F0: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add. -> F1.
- F1: same outputs as F0. -> F2.
- F2: same outputs as F0, plus IRWrite=1, PCWrite=1, PCSource=00. -> DEC.
- DEC: ALUSrcA=0, ALUSrcB=11, add, ALUOutWrite=1, ABWrite=1. Next state by OPCODE:
  - 0x00 -> R_EX if FUNCT is in {0x20, 0x22, 0x24, 0x26}, else EXC_EPC with cause 0.
  - 0x08 -> ADDI_EX.
  - 0x23 or 0x2B -> MEM_ADDR.
  - 0x04 or 0x05 -> BR.
  - 0x02 -> JMP.
  - any other opcode -> EXC_EPC with cause 0.
- R_EX: ALUSrcA=1, ALUSrcB=00, ALUOp from FUNCT (0x20 add, 0x22 sub, 0x24 and, 0x26 xor), ALUOutWrite=1.
  - Overflow=1 and the op is add or sub -> EXC_EPC with cause 1.
  - else -> R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0. -> F0.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, add, ALUOutWrite=1. Overflow=1 -> EXC_EPC with cause 1, else -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0. -> F0.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, add, ALUOutWrite=1. Overflow is ignored. lw -> LW_RD, sw -> SW_WR.
- LW_RD: IorD=1. -> LW_WAIT.
- LW_WAIT: IorD=1. -> LW_WB.
- LW_WB: RegWrite=1, RegDst=0, MemToReg=1. -> F0.
- SW_WR: IorD=1, MemWrite=1. -> F0.
- BR: ALUSrcA=1, ALUSrcB=00, sub, PCSource=01. -> F0.
  - PCWrite = Zero for beq, ~Zero for bne. This is the only Mealy output.
- JMP: PCWrite=1, PCSource=10. -> F0.
- EXC_EPC: ALUSrcA=0, ALUSrcB=01, sub (PC-4), EPCWrite=1. -> EXC_JMP.
  - ExcCause is latched on the transition into EXC_EPC and held until the next exception or reset.
- EXC_JMP: PCWrite=1, PCSource=11. -> F0.
- Exactly one write strobe among {RegWrite, MemWrite, EPCWrite} may be high in any state. An overflow instruction never asserts RegWrite.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum, 5-bit encodings RST=0 through EXC_JMP=17;
  - opcode constants (R, ADDI, LW, SW, BEQ, BNE, J) and funct constants (ADD, SUB, AND, XOR);
  - ALUOp codes and the ALUSrcB and PCSource select codes.
- One natural sub-module: mips_ctrl_decode, a purely combinational block mapping (state, FUNCT, OPCODE[0], Zero) to the control outputs.
- The top level keeps the state register, next-state logic and the ExcCause register.

Test Plan:
- Reset held for 2 cycles, then released -> State=RST with all outputs 0, then F0, F1, F2. PCWrite=1 only in F2, with ALUSrcB=01 and ALUOp=001.
- OPCODE=0x00, FUNCT=0x22, Overflow=0 -> DEC, R_EX (ALUSrcA=1, ALUSrcB=00, ALUOp=010), R_WB (RegWrite=1, RegDst=1), F0. Total 6 cycles from F0 to F0.
- OPCODE=0x23 -> MEM_ADDR (ALUSrcB=10), LW_RD, LW_WAIT, LW_WB (MemToReg=1). OPCODE=0x2B -> SW_WR with MemWrite=1 for exactly 1 cycle.
- OPCODE=0x04 with Zero=1, then with Zero=0 -> PCWrite 1 then 0 in BR, PCSource=01. OPCODE=0x05 -> inverted results. ALUSrcB=11 in the preceding DEC.
- ADDI with Overflow=1 in ADDI_EX -> EXC_EPC (EPCWrite=1, ALUOp=010), EXC_JMP (PCSource=11), ExcCause=1, no RegWrite. OPCODE=0x3F -> same path with ExcCause=0.
- reset asserted during LW_WAIT -> next state RST, no RegWrite ever asserted, fetch restarts at F0.
